// File: rtl/ctrl_interrup_pkg.sv
// ctrl_interrup shared types: source count, id width, FSM states.
// Build option: CTRL_INTERRUP_RR_EN selects rotating priority.
package ctrl_interrup_pkg;
    localparam int NSRC = 4;
    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    function automatic logic [NSRC-1:0] onehot(logic [ID_W-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction
endpackage

// File: rtl/ctrl_interrup_if.sv
// Interrupt controller bus: device lines, mask write, CU handshake.
// Build option: CTRL_INTERRUP_RR_EN (no effect on the bus itself).
interface ctrl_interrup_if;
    import ctrl_interrup_pkg::*;

    logic [NSRC-1:0] irq;
    logic            mask_we;
    logic [NSRC-1:0] mask_in;
    logic            int_ack;
    logic            fin_int;
    logic            int_req;
    logic [9:0]      vector;
    logic [NSRC-1:0] in_service;
    logic [NSRC-1:0] pending;

    modport slave (
        input  irq, mask_we, mask_in, int_ack, fin_int,
        output int_req, vector, in_service, pending
    );

    modport master (
        output irq, mask_we, mask_in, int_ack, fin_int,
        input  int_req, vector, in_service, pending
    );
endinterface

// File: rtl/ctrl_interrup_prio_enc.sv
// Rotating-base priority encoder: first set req at or after base wins.
// Build option: CTRL_INTERRUP_RR_EN drives base from the top.
module prio_enc
    import ctrl_interrup_pkg::*;
(
    input  logic [NSRC-1:0] req,
    input  logic [ID_W-1:0] base,
    output logic [ID_W-1:0] id,
    output logic            valid
);
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest to base wins.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            idx = base + k[ID_W-1:0];
            if (req[idx]) begin
                id    = idx;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ctrl_interrup.sv
// Vectored interrupt controller: edge-latched pending, mask, 3-state FSM.
// Build option: CTRL_INTERRUP_RR_EN enables rotating priority.
module ctrl_interrup
    import ctrl_interrup_pkg::*;
#(
    parameter logic [9:0] VEC_BASE   = 10'd1008,
    parameter logic [9:0] VEC_STRIDE = 10'd4
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_interrup_if.slave bus
);
    state_t          state;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] in_svc;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] base;
    logic [ID_W-1:0] win_id;
    logic            win_valid;
    logic            int_req_r;
    logic [9:0]      vector_r;
    logic            ack_ok;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;

    assign ack_ok = (state == REQ) && bus.int_ack;
    assign rise   = bus.irq & ~irq_q;
    assign clr    = ack_ok ? onehot(id) : '0;

    prio_enc u_prio (
        .req   (pend & mask),
        .base  (base),
        .id    (win_id),
        .valid (win_valid)
    );

`ifdef CTRL_INTERRUP_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            base <= '0;
        else if (ack_ok)
            base <= id + 1'b1;
    end
`else
    assign base = '0;
`endif

    // A new rising edge beats the acknowledge clear of the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= '0;
            pend  <= '0;
            mask  <= '1;
        end else begin
            irq_q <= bus.irq;
            pend  <= (pend & ~clr) | rise;
            if (bus.mask_we)
                mask <= bus.mask_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            id        <= '0;
            int_req_r <= 1'b0;
            vector_r  <= VEC_BASE;
            in_svc    <= '0;
        end else begin
            unique case (state)
                IDLE: if (win_valid) begin
                    state     <= REQ;
                    id        <= win_id;
                    int_req_r <= 1'b1;
                    vector_r  <= VEC_BASE + {8'b0, win_id} * VEC_STRIDE;
                end
                REQ: if (bus.int_ack) begin
                    state     <= SERVICE;
                    in_svc    <= onehot(id);
                    int_req_r <= 1'b0;
                    vector_r  <= VEC_BASE;
                end
                SERVICE: if (bus.fin_int) begin
                    state  <= IDLE;
                    in_svc <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.int_req    = int_req_r;
    assign bus.vector     = vector_r;
    assign bus.in_service = in_svc;
    assign bus.pending    = pend;
endmodule

// File: doc/ctrl_interrup.md
CTRL_INTERRUP -- requirements
Module: ctrl_interrup

Interface
REQ-001 SHALL have parameter VEC_BASE, default 10'd1008, meaning vector address of source 0.
REQ-002 SHALL have parameter VEC_STRIDE, default 10'd4, meaning address distance between consecutive source vectors.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port irq  input  4  interrupt lines from the I/O port devices; bit 0 is source 0.
REQ-006 SHALL have port mask_we  input  1  write enable for the mask register.
REQ-007 SHALL have port mask_in  input  4  new mask value; 1 enables the source.
REQ-008 SHALL have port int_ack  input  1  one-cycle pulse from the control unit: vector taken into the PC.
REQ-009 SHALL have port fin_int  input  1  one-cycle pulse from the control unit: service routine finished.
REQ-010 SHALL have port int_req  output  1  interrupt request to the control unit.
REQ-011 SHALL have port vector  output  10  handler address for the PC multiplexer.
REQ-012 SHALL have port in_service  output  4  one-hot source currently being serviced; 0 when none.
REQ-013 SHALL have port pending  output  4  latched pending flags, for debug and observation.

Function
REQ-014 SHALL register irq into irq_q each cycle; a rising edge is irq & ~irq_q.
REQ-015 SHALL set pending[i] on the clock edge at which bit i shows a rising edge, whatever the mask value.
REQ-016 SHALL update the mask on the edge where mask_we=1; the mask gates eligibility only, never pending.
REQ-017 SHALL run FSM states IDLE, REQ and SERVICE.
REQ-018 SHALL, in IDLE, when (pending & mask)!=0, latch the winner id and move to REQ on the next edge.
REQ-019 SHALL drive int_req=1 exactly while in REQ, with vector = VEC_BASE + id*VEC_STRIDE, held stable.
REQ-020 SHALL not re-arbitrate in REQ, even if the winner becomes masked or a higher-priority source pends.
REQ-021 SHALL, in REQ on int_ack=1, clear pending[id], set in_service to one-hot id and move to SERVICE.
REQ-022 SHALL, in SERVICE on fin_int=1, clear in_service and return to IDLE; no nesting.
REQ-023 SHALL ignore int_ack outside REQ and fin_int outside SERVICE.
REQ-024 SHALL give set priority when pending[id] is cleared and re-set in the same cycle, leaving it 1.
REQ-025 SHALL meet this latency: irq rises before edge t0, pending set at t0, int_req=1 after t1; fin_int at tn allows the next int_req after tn+1.
REQ-026 SHALL drive vector=VEC_BASE whenever int_req=0.

Reset
REQ-027 SHALL, when reset=0, asynchronously force state=IDLE, pending=0, irq_q=0, mask=4'b1111, id=0, in_service=0, int_req=0 and vector=VEC_BASE.
REQ-028 SHALL, when reset is asserted mid-REQ or mid-SERVICE, discard the in-progress request and all pending flags.

Configuration
REQ-029 SHALL, when macro CTRL_INTERRUP_RR_EN is undefined, use fixed priority in which source 0 is highest.
REQ-030 SHALL, when CTRL_INTERRUP_RR_EN is defined, use rotating priority: after int_ack for id k, the highest priority becomes (k+1) mod 4, and reset sets it to 0.

Structure
REQ-031 SHALL place NSRC=4, ID_W=2 and the FSM state enum in package ctrl_interrup_pkg.
REQ-032 SHALL implement winner selection in a combinational sub-module prio_enc with inputs req[3:0] and base[1:0] and outputs id[1:0] and valid.

Verification
REQ-033 SHALL test fixed priority: irq=4'b0110 rises -> int_req after 2 cycles, vector=10'd1012 (id 1); ack, then fin -> next int_req with vector=10'd1016.
REQ-034 SHALL test masking: mask=4'b1110 and irq[0] rises -> no int_req and pending=4'b0001; write mask=4'b1111 -> int_req with vector=10'd1008.
REQ-035 SHALL test handshake: int_ack delayed 5 cycles -> int_req and vector hold for 5 cycles; fin_int pulsed during REQ is ignored.
REQ-036 SHALL test a same-cycle event: irq[2] re-rises on the int_ack cycle for id 2 -> pending[2]=1 remains and it is serviced again after fin_int.
REQ-037 SHALL test reset during SERVICE: in_service=4'b0100, then reset low -> all outputs at reset values at once, with no int_req after release.
REQ-038 SHALL test with CTRL_INTERRUP_RR_EN defined: irq sources 0 and 1 repeatedly pending -> grants alternate 0,1,0,1.
